// File: rtl/wisc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wisc_pkg : shared fetch-state encoding and word-width constants
// Rev 1.0
// ---------------------------------------------------------------------------
package wisc_pkg;

  localparam int WORD_W = 16;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // 2'd3 is unused and recovers to FETCH on the next clock
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/retire_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// retire_counter : wrapping retired-instruction counter, async active-low clear
// Rev 1.0
// ---------------------------------------------------------------------------
module retire_counter
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [WORD_W-1:0] count
);

  // Natural modulo-2^16 wrap on increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + {{(WORD_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_ctrl : PC owner, imem req/ack sequencing and decode handoff with halt
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_ctrl
  import wisc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT[PC_W-1:0]
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [WORD_W-1:0] instr,
  output logic [PC_W-1:0]   instr_pc,
  input  logic              instr_ready,
  output logic [PC_W-1:0]   pc_cur,
  input  logic [PC_W-1:0]   npc,
  input  logic              is_halt,
  output logic              halted,
  output logic [WORD_W-1:0] retire_cnt
);

  fetch_state_t state;
  logic         retire_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc_cur   <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= pc_cur;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            // Halt takes priority: PC stays on the halt instruction
            if (is_halt) begin
              state <= HALT;
            end else begin
              pc_cur <= npc;
              state  <= FETCH;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

  assign retire_en = (state == ISSUE) && instr_ready;

  retire_counter u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (retire_en),
    .count (retire_cnt)
  );

  // Outputs decode registered state only; no input-to-output paths
  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc_cur;
  assign instr_valid = (state == ISSUE);
  assign halted      = (state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_ctrl : directed self-checking bench for fetch_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [15:0] pc_cur;
  logic [15:0] npc;
  logic        is_halt;
  logic        halted;
  logic [15:0] retire_cnt;

  logic        npc_follow;
  logic [15:0] npc_val;

  int checks;
  int failures;

  // Next-PC stimulus: sequential (pc+1) or a directed target
  assign npc = npc_follow ? (pc_cur + 16'd1) : npc_val;

  fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .pc_cur      (pc_cur),
    .npc         (npc),
    .is_halt     (is_halt),
    .halted      (halted),
    .retire_cnt  (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0; instr_ready = 1'b0;
    is_halt = 1'b0; npc_follow = 1'b1; npc_val = 16'h0;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr got=%h exp=0000", imem_addr); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (retire_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", retire_cnt); end
    checks++; if (instr !== 16'h0 || instr_pc !== 16'h0) begin failures++; $display("FAIL reset_instr got=%h/%h exp=0000/0000", instr, instr_pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_wait();
    imem_ack = 1'b1; instr_ready = 1'b1; is_halt = 1'b0; npc_follow = 1'b1;
    for (int k = 0; k < 6; k++) begin
      imem_rdata = 16'h5000 + 16'(k);
      checks++;
      if (imem_req !== ((k % 2) == 0)) begin
        failures++; $display("FAIL zw_req cyc=%0d got=%b exp=%b", k, imem_req, ((k % 2) == 0));
      end
      if ((k % 2) == 0) begin
        checks++;
        if (imem_addr !== 16'(k / 2)) begin failures++; $display("FAIL zw_addr cyc=%0d got=%h exp=%h", k, imem_addr, 16'(k / 2)); end
      end
      step();
    end
    checks++; if (retire_cnt !== 16'd3) begin failures++; $display("FAIL zw_cnt got=%0d exp=3", retire_cnt); end
    checks++; if (imem_addr !== 16'd3 || imem_req !== 1'b1) begin failures++; $display("FAIL zw_next got=%h/%b exp=0003/1", imem_addr, imem_req); end
  endtask

  task automatic test_wait_states();
    // From FETCH at pc 3: fetch, then redirect to 0x0010
    imem_ack = 1'b1; step();
    imem_ack = 1'b0; npc_follow = 1'b0; npc_val = 16'h0010; instr_ready = 1'b1; step();
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imem_ack   = (k == 3);
      imem_rdata = (k == 3) ? 16'hA123 : 16'hDEAD;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
        failures++; $display("FAIL ws_hold cyc=%0d got=%b/%h exp=1/0010", k, imem_req, imem_addr);
      end
      step();
    end
    imem_ack = 1'b0; imem_rdata = 16'hBEEF;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'hA123 || instr_pc !== 16'h0010) begin
      failures++; $display("FAIL ws_latch got=%b/%h/%h exp=1/a123/0010", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0; imem_ack = 1'b1; npc_val = 16'h0020;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'hA123 || instr_pc !== 16'h0010 || imem_req !== 1'b0 || retire_cnt !== 16'd4) begin
        failures++; $display("FAIL stall cyc=%0d got=%b/%h/%h/%b/%0d exp=1/a123/0010/0/4",
                             k, instr_valid, instr, instr_pc, imem_req, retire_cnt);
      end
      step();
    end
    instr_ready = 1'b1; imem_ack = 1'b0; step();
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0020 || retire_cnt !== 16'd5) begin
      failures++; $display("FAIL stall_release got=%b/%h/%0d exp=1/0020/5", imem_req, imem_addr, retire_cnt);
    end
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; imem_rdata = 16'h1111; step();
    imem_ack = 1'b0; npc_val = 16'h0005; instr_ready = 1'b1; step();
    instr_ready = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005 || retire_cnt !== 16'd6) begin
      failures++; $display("FAIL branch got=%b/%h/%0d exp=1/0005/6", imem_req, imem_addr, retire_cnt);
    end
  endtask

  task automatic test_halt();
    imem_ack = 1'b1; imem_rdata = 16'hF000; step();
    imem_ack = 1'b0; is_halt = 1'b1; npc_val = 16'h0099; instr_ready = 1'b1; step();
    checks++; if (halted !== 1'b1 || pc_cur !== 16'h0005 || instr_valid !== 1'b0 || retire_cnt !== 16'd7) begin
      failures++; $display("FAIL halt_enter got=%b/%h/%b/%0d exp=1/0005/0/7", halted, pc_cur, instr_valid, retire_cnt);
    end
    is_halt = 1'b0;
    for (int k = 0; k < 20; k++) begin
      imem_ack = k[0];
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || retire_cnt !== 16'd7) begin
        failures++; $display("FAIL halt_absorb cyc=%0d got=%b/%b/%0d exp=0/1/7", k, imem_req, halted, retire_cnt);
      end
      step();
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    rst_n = 1'b0; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || halted !== 1'b0 || retire_cnt !== 16'd0) begin
      failures++; $display("FAIL halt_reset got=%b/%h/%b/%0d exp=1/0000/0/0", imem_req, imem_addr, halted, retire_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; step();
    imem_ack = 1'b0; npc_val = 16'hFFFF; instr_ready = 1'b1; step();
    instr_ready = 1'b0;
    checks++; if (imem_addr !== 16'hFFFF || imem_req !== 1'b1) begin
      failures++; $display("FAIL wrap_pc_ffff got=%h/%b exp=ffff/1", imem_addr, imem_req);
    end
    imem_ack = 1'b1; step();
    imem_ack = 1'b0;
    force dut.u_retire.count = 16'hFFFF;
    #1;
    release dut.u_retire.count;
    #1;
    checks++; if (retire_cnt !== 16'hFFFF || instr_pc !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload got=%h/%h exp=ffff/ffff", retire_cnt, instr_pc);
    end
    @(negedge clk);
    npc_val = 16'h0000; instr_ready = 1'b1; step();
    instr_ready = 1'b0;
    checks++; if (retire_cnt !== 16'h0000 || imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
      failures++; $display("FAIL wrap got=%h/%h/%b exp=0000/0000/1", retire_cnt, imem_addr, imem_req);
    end
  endtask

  task automatic test_async_reset();
    imem_ack = 1'b1; step();
    imem_ack = 1'b0; npc_val = 16'h0042; instr_ready = 1'b1; step();
    instr_ready = 1'b0; step();
    checks++; if (imem_addr !== 16'h0042 || imem_req !== 1'b1) begin
      failures++; $display("FAIL ar_wait got=%h/%b exp=0042/1", imem_addr, imem_req);
    end
    #2; rst_n = 1'b0; #1;
    checks++; if (imem_addr !== 16'h0000 || imem_req !== 1'b1) begin
      failures++; $display("FAIL ar_async got=%h/%b exp=0000/1", imem_addr, imem_req);
    end
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    step();
    checks++; if (instr_valid !== 1'b0 || instr !== 16'h0000 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL ar_ack_ignored got=%b/%h/%h exp=0/0000/0000", instr_valid, instr, imem_addr);
    end
    rst_n = 1'b1; step();
    imem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr !== 16'h7777 || instr_pc !== 16'h0000) begin
      failures++; $display("FAIL ar_refetch got=%b/%h/%h exp=1/7777/0000", instr_valid, instr, instr_pc);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
